// File: rtl/parallel_io_pkg.sv
// Shared definitions for the memory-mapped parallel I/O blocks.
// Used by both the input port and the output register.
package parallel_io_pkg;

    localparam logic [7:0] IO_ADDR = 8'hFF;

    typedef logic [7:0] io_byte_t;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for an asynchronous bus.
// No logic is placed ahead of the first flop.
module io_sync2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/parallel_in.sv
// Memory-mapped 8-bit parallel input port with sticky change flag.
// Optional debounce stage enabled by PARALLEL_IN_DEBOUNCE_EN.
module parallel_in
    import parallel_io_pkg::*;
#(
    parameter logic [7:0]  IO_ADDR         = parallel_io_pkg::IO_ADDR,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Address,
    input  logic       re,
    input  logic [7:0] MemData,
    input  logic [7:0] ExtIn,
    output logic [7:0] ReadData,
    output logic       rden,
    output logic       changed
);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    io_byte_t sync2;
    io_byte_t in_reg;
    io_byte_t in_nxt;
    logic     hit;
    logic     set_chg;
    logic     clr_chg;

    io_sync2 #(
        .W(8)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ExtIn),
        .q    (sync2)
    );

`ifdef PARALLEL_IN_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

    io_byte_t      cand;
    logic [CW-1:0] cnt;

    // Any difference from the candidate restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt < CMAX) begin
            cnt  <= cnt + 1'b1;
        end
    end

    assign in_nxt = (cnt == CMAX) ? cand : in_reg;
`else
    assign in_nxt = sync2;
`endif

    assign hit      = (Address == IO_ADDR);
    assign ReadData = hit ? in_reg : MemData;
    assign rden     = re & ~hit;
    assign set_chg  = (in_nxt != in_reg);
    assign clr_chg  = re & hit;

    // A new value wins over a concurrent clearing read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reg  <= '0;
            changed <= 1'b0;
        end else begin
            in_reg <= in_nxt;
            if (set_chg) begin
                changed <= 1'b1;
            end else if (clr_chg) begin
                changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parallel_in.sv
// Self-checking bench for parallel_in against a history-window model.
// Build with PARALLEL_IN_DEBOUNCE_EN to exercise the debounce stage.
module tb_parallel_in;

    localparam int D = 4;
`ifdef PARALLEL_IN_DEBOUNCE_EN
    localparam int LAT = 4 + D;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] address;
    logic       re;
    logic [7:0] mem_data;
    logic [7:0] ext_in;
    logic [7:0] read_data;
    logic       rden;
    logic       changed;

    int checks;
    int fails;

    logic [7:0] hist[$];
    logic [7:0] m_inreg;
    logic       m_chg;

    parallel_in #(
        .IO_ADDR        (8'hFF),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Address (address),
        .re      (re),
        .MemData (mem_data),
        .ExtIn   (ext_in),
        .ReadData(read_data),
        .rden    (rden),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Value ExtIn had m posedges ago; zeros before reset release.
    function automatic logic [7:0] h(int m);
        if (hist.size() > m) return hist[hist.size() - 1 - m];
        return 8'h00;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_inreg = 8'h00;
        m_chg   = 1'b0;
    endtask

    task automatic tick();
        logic [7:0] nxt;
        bit         ok;
        @(posedge clk);
        if (rst_n) begin
            hist.push_back(ext_in);
            if (hist.size() > 64) void'(hist.pop_front());
            nxt = m_inreg;
`ifdef PARALLEL_IN_DEBOUNCE_EN
            ok = 1'b1;
            for (int j = 3; j <= 3 + D; j++)
                if (h(j) != h(3)) ok = 1'b0;
            if (ok) nxt = h(3);
`else
            ok  = 1'b1;
            nxt = h(2);
`endif
            if (nxt != m_inreg) m_chg = 1'b1;
            else if (ok && re && address == 8'hFF) m_chg = 1'b0;
            else if (re && address == 8'hFF) m_chg = 1'b0;
            m_inreg = nxt;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ext_in = 8'hA5; address = 8'hFF;
        re = 1'b0; mem_data = 8'h00;
        model_reset();
        repeat (3) tick();
        checks++;
        if (read_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_rd: got %h want 00", read_data);
        end
        checks++;
        if (changed !== 1'b0) begin
            fails++;
            $display("FAIL reset_chg: got %b want 0", changed);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i == LAT - 1) begin
                checks++;
                if (read_data !== 8'h00) begin
                    fails++;
                    $display("FAIL reset_early: got %h want 00", read_data);
                end
            end
        end
        checks++;
        if (read_data !== 8'hA5 || changed !== 1'b1) begin
            fails++;
            $display("FAIL reset_capture: rd %h chg %b want A5 1",
                     read_data, changed);
        end
    endtask

    task automatic test_decode();
        mem_data = 8'h3C; address = 8'h10; re = 1'b1;
        #1;
        checks++;
        if (read_data !== 8'h3C || rden !== 1'b1) begin
            fails++;
            $display("FAIL decode_ram: rd %h rden %b want 3C 1",
                     read_data, rden);
        end
        address = 8'hFF;
        #1;
        checks++;
        if (read_data !== m_inreg || rden !== 1'b0) begin
            fails++;
            $display("FAIL decode_io: rd %h rden %b want %h 0",
                     read_data, rden, m_inreg);
        end
        re = 1'b0; address = 8'h10;
        #1;
        checks++;
        if (rden !== 1'b0) begin
            fails++;
            $display("FAIL decode_nore: rden %b want 0", rden);
        end
    endtask

    task automatic test_flag_clear();
        address = 8'hFF; re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if (changed !== 1'b0) begin
            fails++;
            $display("FAIL clear_io: got %b want 0", changed);
        end
        ext_in = 8'h3C;
        repeat (LAT + 1) tick();
        checks++;
        if (changed !== 1'b1) begin
            fails++;
            $display("FAIL clear_reset: got %b want 1", changed);
        end
        address = 8'h10; re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if (changed !== 1'b1) begin
            fails++;
            $display("FAIL clear_ram: got %b want 1", changed);
        end
    endtask

    task automatic test_simultaneous();
        ext_in = 8'h00;
        repeat (LAT + 2) tick();
        address = 8'hFF; re = 1'b1;
        tick();
        re = 1'b0;
        checks++;
        if (changed !== 1'b0 || read_data !== 8'h00) begin
            fails++;
            $display("FAIL simul_pre: chg %b rd %h want 0 00",
                     changed, read_data);
        end
        ext_in = 8'h5A;
        repeat (LAT - 1) tick();
        address = 8'hFF; re = 1'b1;
        #1;
        checks++;
        if (read_data !== 8'h00) begin
            fails++;
            $display("FAIL simul_old: rd %h want 00", read_data);
        end
        tick();
        re = 1'b0;
        checks++;
        if (changed !== 1'b1 || read_data !== 8'h5A) begin
            fails++;
            $display("FAIL simul_keep: chg %b rd %h want 1 5A",
                     changed, read_data);
        end
    endtask

`ifdef PARALLEL_IN_DEBOUNCE_EN
    task automatic test_debounce();
        bit bad;
        ext_in = 8'h00; address = 8'hFF;
        repeat (LAT + 2) tick();
        re = 1'b1;
        tick();
        re = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ext_in = ((i / 2) % 2 != 0) ? 8'hFF : 8'h00;
            tick();
            if (read_data !== 8'h00 || changed !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL debounce_bounce: rd %h chg %b want 00 0",
                     read_data, changed);
        end
        for (int p = 3; p <= 4 + D; p++) begin
            tick();
            if (p == 3 + D) begin
                checks++;
                if (read_data !== 8'h00) begin
                    fails++;
                    $display("FAIL debounce_early: rd %h want 00",
                             read_data);
                end
            end
        end
        checks++;
        if (read_data !== 8'hFF || changed !== 1'b1) begin
            fails++;
            $display("FAIL debounce_accept: rd %h chg %b want FF 1",
                     read_data, changed);
        end
    endtask
`endif

    task automatic test_async_reset();
        ext_in = 8'hFF; address = 8'hFF; re = 1'b0;
        repeat (LAT + 2) tick();
        ext_in = 8'h00;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (read_data !== 8'h00 || changed !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: rd %h chg %b want 00 0",
                     read_data, changed);
        end
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        ext_in = 8'hC3;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i == LAT - 1) begin
                checks++;
                if (read_data !== 8'h00) begin
                    fails++;
                    $display("FAIL async_early: rd %h want 00", read_data);
                end
            end
        end
        checks++;
        if (read_data !== 8'hC3 || changed !== 1'b1) begin
            fails++;
            $display("FAIL async_capture: rd %h chg %b want C3 1",
                     read_data, changed);
        end
    endtask

    task automatic test_random();
        int         hold;
        logic [7:0] exp_rd;
        logic       exp_rden;
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                ext_in = 8'($urandom);
                hold   = $urandom_range(1, D + 5);
            end
            hold--;
            address  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            re       = 1'($urandom);
            mem_data = 8'($urandom);
            #1;
            exp_rd   = (address == 8'hFF) ? m_inreg : mem_data;
            exp_rden = re && (address != 8'hFF);
            checks++;
            if (read_data !== exp_rd || rden !== exp_rden) begin
                fails++;
                $display("FAIL rand_rd[%0d]: rd %h rden %b want %h %b",
                         i, read_data, rden, exp_rd, exp_rden);
            end
            tick();
            checks++;
            if (changed !== m_chg) begin
                fails++;
                $display("FAIL rand_chg[%0d]: got %b want %b",
                         i, changed, m_chg);
            end
        end
        re = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_decode();
        test_flag_clear();
        test_simultaneous();
`ifdef PARALLEL_IN_DEBOUNCE_EN
        test_debounce();
`endif
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
